au_accum_sequencer: RTL and testbench

//  Sequencing/accumulator stage wrapped around the 8-bit full adder/subtracter (external comb. AU).

---
 rtl/au_accum_sequencer_if.sv | 34 +++
 rtl/au_accum_sequencer.sv | 106 ++++++++++
 tb/tb_au_accum_sequencer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/au_accum_sequencer_if.sv
// Command, AU and result signal bundle for au_accum_sequencer.
// The slave modport is the sequencer; the master modport is the command/AU/consumer side.
interface au_accum_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic [7:0] au_a;
  logic [7:0] au_b;
  logic       au_sub;
  logic [7:0] au_s;
  logic       au_cout;
  logic       au_ovr;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_cout;
  logic       res_ovr;
  logic       res_zero;
  logic       res_neg;
  logic       ovr_sticky;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, au_s, au_cout, au_ovr, res_ready,
    output cmd_ready, au_a, au_b, au_sub, res_valid, res_data, res_cout, res_ovr,
           res_zero, res_neg, ovr_sticky
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, au_s, au_cout, au_ovr, res_ready,
    input  cmd_ready, au_a, au_b, au_sub, res_valid, res_data, res_cout, res_ovr,
           res_zero, res_neg, ovr_sticky
  );
endinterface

// File: rtl/au_accum_sequencer.sv
// Accumulator sequencer around an external 8-bit add/sub unit: IDLE -> EXEC -> RESP,
// one command per three cycles, result held under backpressure.
module au_accum_sequencer #(
  parameter logic [7:0] ACC_INIT = 8'h00,
  parameter bit         SAT_EN   = 1'b0
) (
  input logic                 clk,
  input logic                 rst,
  au_accum_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;
  typedef enum logic [1:0] {OpLoad = 2'b00, OpAdd = 2'b01, OpSub = 2'b10, OpClr = 2'b11} op_e;

  state_e     r_state, w_state_d;
  logic [1:0] r_op, w_op_d;
  logic [7:0] r_opnd, w_opnd_d;
  logic [7:0] r_acc, w_acc_d;
  logic       r_res_cout, w_res_cout_d;
  logic       r_res_ovr, w_res_ovr_d;
  logic       r_ovr_sticky, w_ovr_sticky_d;
  logic       w_sub;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_op         <= 2'b00;
      r_opnd       <= 8'h00;
      r_acc        <= ACC_INIT;
      r_res_cout   <= 1'b0;
      r_res_ovr    <= 1'b0;
      r_ovr_sticky <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_op         <= w_op_d;
      r_opnd       <= w_opnd_d;
      r_acc        <= w_acc_d;
      r_res_cout   <= w_res_cout_d;
      r_res_ovr    <= w_res_ovr_d;
      r_ovr_sticky <= w_ovr_sticky_d;
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_op_d         = r_op;
    w_opnd_d       = r_opnd;
    w_acc_d        = r_acc;
    w_res_cout_d   = r_res_cout;
    w_res_ovr_d    = r_res_ovr;
    w_ovr_sticky_d = r_ovr_sticky;
    w_sub          = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.cmd_valid) begin
          w_state_d = StExec;
          w_op_d    = bus.cmd_op;
          w_opnd_d  = bus.cmd_data;
        end
      end
      StExec: begin
        w_sub     = (r_op == OpSub);
        w_state_d = StResp;
        unique case (r_op)
          OpLoad: begin
            w_acc_d      = r_opnd;
            w_res_cout_d = 1'b0;
            w_res_ovr_d  = 1'b0;
          end
          OpClr: begin
            w_acc_d        = ACC_INIT;
            w_res_cout_d   = 1'b0;
            w_res_ovr_d    = 1'b0;
            w_ovr_sticky_d = 1'b0;
          end
          OpAdd, OpSub: begin
            // Saturate toward the sign of A: overflow can only go past the rail A was near.
            if (SAT_EN && bus.au_ovr) w_acc_d = r_acc[7] ? 8'h80 : 8'h7F;
            else                      w_acc_d = bus.au_s;
            w_res_cout_d   = bus.au_cout;
            w_res_ovr_d    = bus.au_ovr;
            w_ovr_sticky_d = r_ovr_sticky | bus.au_ovr;
          end
          default: ;
        endcase
      end
      StResp: begin
        if (bus.res_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign bus.cmd_ready  = (r_state == StIdle);
  assign bus.res_valid  = (r_state == StResp);
  assign bus.au_a       = r_acc;
  assign bus.au_b       = r_opnd;
  assign bus.au_sub     = w_sub;
  assign bus.res_data   = r_acc;
  assign bus.res_cout   = r_res_cout;
  assign bus.res_ovr    = r_res_ovr;
  assign bus.res_zero   = (r_acc == 8'h00);
  assign bus.res_neg    = r_acc[7];
  assign bus.ovr_sticky = r_ovr_sticky;

endmodule

// File: tb/tb_au_accum_sequencer.sv
// Directed bench: wrap (SAT_EN=0) and saturating (SAT_EN=1) instances behind a behavioural AU.
module tb_au_accum_sequencer;

  localparam logic [1:0] OpLoad = 2'b00;
  localparam logic [1:0] OpAdd  = 2'b01;
  localparam logic [1:0] OpSub  = 2'b10;
  localparam logic [1:0] OpClr  = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       tb_valid = 1'b0;
  logic [1:0] tb_op = 2'b00;
  logic [7:0] tb_data = 8'h00;
  logic       tb_res_ready = 1'b0;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  au_accum_sequencer_if if0 ();
  au_accum_sequencer_if if1 ();

  au_accum_sequencer #(.ACC_INIT(8'h00), .SAT_EN(1'b0)) u_wrap (.clk(clk), .rst(rst), .bus(if0));
  au_accum_sequencer #(.ACC_INIT(8'h00), .SAT_EN(1'b1)) u_sat  (.clk(clk), .rst(rst), .bus(if1));

  // Reference adder/subtracter: returns {ovr, cout, s}
  function automatic logic [9:0] au_model(input logic [7:0] a, input logic [7:0] b,
                                          input logic sub);
    logic [7:0] bx;
    logic [8:0] sum;
    bx  = sub ? ~b : b;
    sum = {1'b0, a} + {1'b0, bx} + {8'h00, sub};
    return {(a[7] == bx[7]) && (sum[7] != a[7]), sum[8], sum[7:0]};
  endfunction

  assign {if0.au_ovr, if0.au_cout, if0.au_s} = au_model(if0.au_a, if0.au_b, if0.au_sub);
  assign {if1.au_ovr, if1.au_cout, if1.au_s} = au_model(if1.au_a, if1.au_b, if1.au_sub);

  assign if0.cmd_valid = tb_valid & ~sel;
  assign if1.cmd_valid = tb_valid & sel;
  assign if0.cmd_op    = tb_op;
  assign if1.cmd_op    = tb_op;
  assign if0.cmd_data  = tb_data;
  assign if1.cmd_data  = tb_data;
  assign if0.res_ready = tb_res_ready;
  assign if1.res_ready = tb_res_ready;

  wire       o_cmd_ready = sel ? if1.cmd_ready  : if0.cmd_ready;
  wire       o_res_valid = sel ? if1.res_valid  : if0.res_valid;
  wire [7:0] o_res_data  = sel ? if1.res_data   : if0.res_data;
  wire       o_res_cout  = sel ? if1.res_cout   : if0.res_cout;
  wire       o_res_ovr   = sel ? if1.res_ovr    : if0.res_ovr;
  wire       o_res_zero  = sel ? if1.res_zero   : if0.res_zero;
  wire       o_res_neg   = sel ? if1.res_neg    : if0.res_neg;
  wire       o_sticky    = sel ? if1.ovr_sticky : if0.ovr_sticky;
  wire [7:0] o_au_a      = sel ? if1.au_a       : if0.au_a;
  wire [7:0] o_au_b      = sel ? if1.au_b       : if0.au_b;
  wire       o_au_sub    = sel ? if1.au_sub     : if0.au_sub;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  // Present a command, return one cycle after acceptance (FSM in EXEC).
  task automatic issue(input logic [1:0] op, input logic [7:0] d);
    int n;
    n        = 0;
    tb_op    = op;
    tb_data  = d;
    tb_valid = 1'b1;
    while (!o_cmd_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) check_eq("cmd_ready_timeout", {7'd0, o_cmd_ready}, 8'h01);
    @(posedge clk); #1;
    tb_valid = 1'b0;
    check_eq("exec_not_ready", {7'd0, o_cmd_ready}, 8'h00);
    check_eq("exec_no_valid", {7'd0, o_res_valid}, 8'h00);
  endtask

  // Advance from EXEC into RESP: res_valid must be up exactly here (N+2).
  task automatic to_resp;
    @(posedge clk); #1;
    check_eq("latency_res_valid", {7'd0, o_res_valid}, 8'h01);
  endtask

  task automatic ack;
    tb_res_ready = 1'b1;
    @(posedge clk); #1;
    tb_res_ready = 1'b0;
    check_eq("ack_valid_drop", {7'd0, o_res_valid}, 8'h00);
    check_eq("ack_ready_back", {7'd0, o_cmd_ready}, 8'h01);
  endtask

  task automatic check_res(input string tag, input logic [7:0] data, input logic cout,
                           input logic ovr, input logic sticky);
    check_eq({tag, "_data"}, o_res_data, data);
    check_eq({tag, "_cout"}, {7'd0, o_res_cout}, {7'd0, cout});
    check_eq({tag, "_ovr"}, {7'd0, o_res_ovr}, {7'd0, ovr});
    check_eq({tag, "_zero"}, {7'd0, o_res_zero}, {7'd0, data == 8'h00});
    check_eq({tag, "_neg"}, {7'd0, o_res_neg}, {7'd0, data[7]});
    check_eq({tag, "_sticky"}, {7'd0, o_sticky}, {7'd0, sticky});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    // Reset state
    check_eq("rst_cmd_ready", {7'd0, o_cmd_ready}, 8'h01);
    check_eq("rst_res_valid", {7'd0, o_res_valid}, 8'h00);
    check_eq("rst_au_sub", {7'd0, o_au_sub}, 8'h00);
    check_eq("rst_au_b", o_au_b, 8'h00);
    check_res("rst", 8'h00, 1'b0, 1'b0, 1'b0);

    // Reset while a command is executing
    issue(OpLoad, 8'h33); to_resp; check_res("ld33", 8'h33, 1'b0, 1'b0, 1'b0); ack;
    issue(OpAdd, 8'h01);
    check_eq("t1_exec_au_a", o_au_a, 8'h33);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("t1_acc", o_au_a, 8'h00);
    check_eq("t1_res_valid", {7'd0, o_res_valid}, 8'h00);
    check_eq("t1_cmd_ready", {7'd0, o_cmd_ready}, 8'h01);
    check_res("t1", 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_eq("t1_no_resume", {7'd0, o_res_valid}, 8'h00);

    // Signed overflow on ADD, then CLR clears sticky
    issue(OpLoad, 8'h7F); to_resp; check_res("ld7f", 8'h7F, 1'b0, 1'b0, 1'b0); ack;
    issue(OpAdd, 8'h01);
    check_eq("t2_au_a", o_au_a, 8'h7F);
    check_eq("t2_au_b", o_au_b, 8'h01);
    check_eq("t2_au_sub", {7'd0, o_au_sub}, 8'h00);
    to_resp; check_res("t2", 8'h80, 1'b0, 1'b1, 1'b1); ack;
    issue(OpClr, 8'h5A); to_resp; check_res("t6_clr", 8'h00, 1'b0, 1'b0, 1'b0); ack;

    // SUB to zero
    issue(OpLoad, 8'h05); to_resp; ack;
    issue(OpSub, 8'h05);
    check_eq("t3_au_sub", {7'd0, o_au_sub}, 8'h01);
    to_resp; check_res("t3", 8'h00, 1'b1, 1'b0, 1'b0);
    check_eq("t3_resp_au_sub", {7'd0, o_au_sub}, 8'h00);
    ack;

    // Backpressure: result held, competing command ignored
    issue(OpLoad, 8'h10); to_resp; ack;
    issue(OpAdd, 8'h22); to_resp;
    tb_op = OpLoad; tb_data = 8'hAA; tb_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("t5_hold_valid", {7'd0, o_res_valid}, 8'h01);
      check_eq("t5_hold_ready", {7'd0, o_cmd_ready}, 8'h00);
      check_res("t5_hold", 8'h32, 1'b0, 1'b0, 1'b0);
    end
    tb_valid = 1'b0;
    ack;
    check_eq("t5_acc_kept", o_au_a, 8'h32);

    // Wrap instance: 0x80 - 1 wraps to 0x7F
    issue(OpLoad, 8'h80); to_resp; ack;
    issue(OpSub, 8'h01); to_resp; check_res("wrap", 8'h7F, 1'b1, 1'b1, 1'b1); ack;

    // Saturating instance
    sel = 1'b1;
    #1;
    check_eq("sat_idle_sticky", {7'd0, o_sticky}, 8'h00);
    issue(OpLoad, 8'h80); to_resp; ack;
    issue(OpSub, 8'h01); to_resp; check_res("t4_sat", 8'h80, 1'b1, 1'b1, 1'b1); ack;
    issue(OpLoad, 8'h70); to_resp; ack;
    issue(OpAdd, 8'h20); to_resp; check_res("t4_satpos", 8'h7F, 1'b0, 1'b1, 1'b1); ack;
    issue(OpClr, 8'h00); to_resp; check_res("t4_clr", 8'h00, 1'b0, 1'b0, 1'b0); ack;
    issue(OpAdd, 8'hFF); to_resp; check_res("t4_nosat", 8'hFF, 1'b0, 1'b0, 1'b0); ack;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
